mux_4x1_rr_ctrl: RTL and testbench

Round-robin select controller that sits directly upstream of mux_4x1. It arbitrates four request lines and drives the mux select lines s1/s0. It waits a settle interval, samples the mux output and presents the sampled bit with its channel number on a valid/ready output port. Each granted requester receives a one-cycle ack pulse when its bit has been consumed.

---
 rtl/mux_4x1_rr_ctrl_pkg.sv | 19 +
 rtl/mux_4x1_rr_ctrl_pick.sv | 28 ++
 rtl/mux_4x1_rr_ctrl.sv | 79 +++++++
 tb/tb_mux_4x1_rr_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_4x1_rr_ctrl_pkg.sv
// Shared constants and types for the round-robin mux select controller.
// Channel count, state encoding and the pointer wrap helper.
package mux_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Channel after ch, wrapping 3 -> 0 through the natural CH_W overflow.
    function automatic logic [CH_W-1:0] ch_next(input logic [CH_W-1:0] ch);
        return ch + 1'b1;
    endfunction

endpackage

// File: rtl/mux_4x1_rr_ctrl_pick.sv
// Combinational round-robin picker: first set request at ptr, ptr+1, ptr+2, ptr+3.
// gnt_any is low when no request is set.
module rr_pick_4
    import mux_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [CH_W-1:0]   gnt_idx,
    output logic              gnt_any
);

    logic [CH_W-1:0] idx;

    // Walk from the farthest offset down so the nearest-to-ptr hit wins.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = ptr + CH_W'(i);
            if (req[idx]) begin
                gnt_idx = idx;
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_4x1_rr_ctrl.sv
// Round-robin select controller upstream of mux_4x1: grants a requester, holds the
// select for SETTLE_CYCLES, samples mux_out onto a valid/ready port and acks the requester.
module mux_4x1_rr_ctrl
    import mux_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              mux_out,
    output logic              s1,
    output logic              s0,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic [NUM_CH-1:0] ack
);

    state_t          state;
    logic [CH_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;
    logic [CH_W-1:0] gnt_idx;
    logic            gnt_any;

    rr_pick_4 u_pick (
        .req     (req),
        .ptr     (ptr),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            s1        <= 1'b0;
            s0        <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 1'b0;
            out_ch    <= '0;
            ack       <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    // req is only looked at here; the select stays put otherwise.
                    if (gnt_any) begin
                        {s1, s0} <= gnt_idx;
                        cnt      <= CNT_W'(SETTLE_CYCLES);
                        state    <= SETTLE;
                    end
                end
                SETTLE: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        out_data  <= mux_out;
                        out_ch    <= {s1, s0};
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        ack[out_ch] <= 1'b1;
                        ptr         <= ch_next(out_ch);
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_4x1_rr_ctrl.sv
// Scoreboard bench: two controllers (settle 1 and 3) driving a behavioural mux_4x1.
// Stimulus pushes expected {ch,data}; per-instance monitors pop on handshake and check ack.
module tb_mux_4x1_rr_ctrl;

    typedef struct {
        int         inst;
        logic [1:0] ch;
        logic       d;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req [2];
    logic [3:0] mdat [2];
    logic       mux_out [2];
    logic       s1 [2];
    logic       s0 [2];
    logic       out_valid [2];
    logic       out_ready [2];
    logic       out_data [2];
    logic [1:0] out_ch [2];
    logic [3:0] ack [2];

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   hs [2] = '{0, 0};

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int inst, input logic [1:0] ch, input logic d);
        exp_t e;
        e.inst = inst;
        e.ch   = ch;
        e.d    = d;
        sb.push_back(e);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_u
        logic [3:0] exp_ack = '0;
        logic       stall = 1'b0;
        logic       pd = 1'b0;
        logic [1:0] pc = '0;

        assign mux_out[g] = mdat[g][{s1[g], s0[g]}];

        mux_4x1_rr_ctrl #(.SETTLE_CYCLES(g == 0 ? 1 : 3), .CNT_W(4)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req       (req[g]),
            .mux_out   (mux_out[g]),
            .s1        (s1[g]),
            .s0        (s0[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .out_ch    (out_ch[g]),
            .ack       (ack[g])
        );

        always @(negedge clk) begin
            exp_t e;
            chk($sformatf("ack%0d", g), 32'(ack[g]), 32'(exp_ack));
            if (stall && rst_n) begin
                chk($sformatf("hold_valid%0d", g), 32'(out_valid[g]), 32'd1);
                chk($sformatf("hold_data%0d", g), 32'(out_data[g]), 32'(pd));
                chk($sformatf("hold_ch%0d", g), 32'(out_ch[g]), 32'(pc));
            end
            exp_ack = '0;
            stall   = rst_n && out_valid[g] && !out_ready[g];
            pd      = out_data[g];
            pc      = out_ch[g];
            if (rst_n && out_valid[g] && out_ready[g]) begin
                exp_ack = 4'b0001 << out_ch[g];
                hs[g]++;
                if (sb.size() == 0) begin
                    chk($sformatf("sb_empty%0d", g), 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("sb_inst%0d", g), 32'(g), 32'(e.inst));
                    chk($sformatf("out_ch%0d", g), 32'(out_ch[g]), 32'(e.ch));
                    chk($sformatf("out_data%0d", g), 32'(out_data[g]), 32'(e.d));
                end
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        req[0]       = 4'b1111;
        req[1]       = 4'b0000;
        mdat[0]      = 4'b0101;
        mdat[1]      = 4'b1000;
        out_ready[0] = 1'b0;
        out_ready[1] = 1'b1;
        repeat (2) tick();
        chk("rst_s1", 32'(s1[0]), 32'd0);
        chk("rst_s0", 32'(s0[0]), 32'd0);
        chk("rst_valid", 32'(out_valid[0]), 32'd0);
        chk("rst_ack", 32'(ack[0]), 32'd0);
        chk("rst_data", 32'(out_data[0]), 32'd0);
        chk("rst_ch", 32'(out_ch[0]), 32'd0);

        // Round robin over all four with a=1,b=0,c=1,d=0, one transfer per 3 cycles
        push(0, 2'd0, 1'b1);
        push(0, 2'd1, 1'b0);
        push(0, 2'd2, 1'b1);
        push(0, 2'd3, 1'b0);
        push(0, 2'd0, 1'b1);
        out_ready[0] = 1'b1;
        rst_n        = 1'b1;
        tick();
        chk("rr_sel0", 32'({s1[0], s0[0]}), 32'd0);
        chk("rr_valid_lat0", 32'(out_valid[0]), 32'd0);
        tick();
        chk("rr_valid_lat1", 32'(out_valid[0]), 32'd1);
        repeat (13) tick();
        req[0] = 4'b0000;
        chk("rr_rate", 32'(hs[0]), 32'd5);

        // Single channel c
        mdat[0] = 4'b0100;
        req[0]  = 4'b0100;
        push(0, 2'd2, 1'b1);
        tick();
        req[0] = 4'b0000;
        chk("single_sel", 32'({s1[0], s0[0]}), 32'd2);
        chk("single_valid0", 32'(out_valid[0]), 32'd0);
        tick();
        chk("single_valid1", 32'(out_valid[0]), 32'd1);
        chk("single_data", 32'(out_data[0]), 32'd1);
        chk("single_ch", 32'(out_ch[0]), 32'd2);
        tick();
        chk("single_done", 32'(out_valid[0]), 32'd0);
        tick();

        // Backpressure on channel b
        out_ready[0] = 1'b0;
        mdat[0]      = 4'b0010;
        req[0]       = 4'b0010;
        push(0, 2'd1, 1'b1);
        tick();
        req[0] = 4'b0000;
        tick();
        chk("bp_valid", 32'(out_valid[0]), 32'd1);
        repeat (5) tick();
        chk("bp_still", 32'(out_valid[0]), 32'd1);
        out_ready[0] = 1'b1;
        tick();
        chk("bp_release", 32'(out_valid[0]), 32'd0);
        tick();

        // Async reset while holding channel d; no ack, pointer back to 0
        out_ready[0] = 1'b0;
        mdat[0]      = 4'b0000;
        req[0]       = 4'b1000;
        tick();
        chk("rh_sel", 32'({s1[0], s0[0]}), 32'd3);
        req[0] = 4'b0000;
        tick();
        chk("rh_valid", 32'(out_valid[0]), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("rh_async_valid", 32'(out_valid[0]), 32'd0);
        chk("rh_async_sel", 32'({s1[0], s0[0]}), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        out_ready[0] = 1'b1;
        mdat[0]      = 4'b0001;
        req[0]       = 4'b1001;
        push(0, 2'd0, 1'b1);
        tick();
        req[0] = 4'b0000;
        chk("rh_ptr0", 32'({s1[0], s0[0]}), 32'd0);
        repeat (3) tick();

        // Settle of 3 with the request dropped one cycle after grant
        req[1] = 4'b1000;
        push(1, 2'd3, 1'b1);
        tick();
        chk("s3_sel", 32'({s1[1], s0[1]}), 32'd3);
        chk("s3_valid_k", 32'(out_valid[1]), 32'd0);
        tick();
        req[1] = 4'b0000;
        chk("s3_valid_k1", 32'(out_valid[1]), 32'd0);
        tick();
        chk("s3_valid_k2", 32'(out_valid[1]), 32'd0);
        tick();
        chk("s3_valid_k3", 32'(out_valid[1]), 32'd1);
        chk("s3_ch", 32'(out_ch[1]), 32'd3);
        repeat (3) tick();

        chk("sb_drain", 32'(sb.size()), 32'd0);
        chk("hs_count0", 32'(hs[0]), 32'd8);
        chk("hs_count1", 32'(hs[1]), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
